// File: rtl/tdm_demux4_pkg.sv
// Shared constants for the 4-channel TDM receive path.
package tdm_demux4_pkg;
    localparam logic [0:0]  ST_HUNT = 1'b0;
    localparam logic [0:0]  ST_LOCK = 1'b1;
    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned SLOT_W  = 2;
endpackage

// File: rtl/tdm_chan_shreg.sv
// Per-channel MSB-first deserializing shift register.
module tdm_chan_shreg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// 1-to-4 TDM demultiplexer: frame lock, channel routing and a registered
// parallel word-set output with valid/ready handshake.
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din,
    input  logic                    din_valid,
    input  logic                    frame_sync,
    output logic [NUM_CH*WIDTH-1:0] dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    locked,
    output logic                    sync_err,
    output logic                    overrun
);

    localparam int unsigned BCNT_W = $clog2(WIDTH);

    logic [0:0]        state, stateNext;
    logic [SLOT_W-1:0] slot, slotNext, chSel;
    logic [BCNT_W-1:0] bcnt, bcntNext;
    logic              misplaced, beat, restart, complete;
    logic [NUM_CH-1:0] chEn;
    logic [WIDTH-1:0]  chQ [NUM_CH];
    logic [WIDTH-1:0]  ch3Next;
    logic              unusedCh3Msb;

    // State and counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_HUNT;
            slot  <= '0;
            bcnt  <= '0;
        end else begin
            state <= stateNext;
            slot  <= slotNext;
            bcnt  <= bcntNext;
        end
    end

    // Next-state, slot/bit counting and channel decode.
    always_comb begin
        stateNext = state;
        slotNext  = slot;
        bcntNext  = bcnt;
        complete  = 1'b0;
        misplaced = (state == ST_LOCK) && frame_sync && (slot != '0);
        beat      = din_valid && ((state == ST_LOCK) || frame_sync);
        restart   = (state == ST_HUNT) || misplaced;
        chSel     = restart ? '0 : slot;
        if (beat) begin
            stateNext = ST_LOCK;
            if (restart) begin
                slotNext = SLOT_W'(1);
                bcntNext = '0;
            end else begin
                slotNext = slot + SLOT_W'(1);
                if (slot == SLOT_W'(NUM_CH - 1)) begin
                    if (bcnt == BCNT_W'(WIDTH - 1)) begin
                        complete = 1'b1;
                        bcntNext = '0;
                    end else begin
                        bcntNext = bcnt + BCNT_W'(1);
                    end
                end
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            chEn[k] = beat && (chSel == SLOT_W'(k));
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : gCh
        tdm_chan_shreg #(.WIDTH(WIDTH)) uShreg (
            .clk (clk),
            .rst (rst),
            .en  (chEn[k]),
            .din (din),
            .q   (chQ[k])
        );
    end

    // ch3 finishes on the completing beat, so its word is taken pre-shift.
    assign ch3Next      = {chQ[3][WIDTH-2:0], din};
    assign unusedCh3Msb = chQ[3][WIDTH-1];
    assign locked       = state[0];

    // Output word-set register, handshake and error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync_err <= din_valid && misplaced;
            if (complete) begin
                if (!dout_valid || dout_ready) begin
                    dout       <= {ch3Next, chQ[2], chQ[1], chQ[0]};
                    dout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Randomized self-checking bench for tdm_demux4 against a beat-count model.
module tb_tdm_demux4;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          din = 1'b0;
    logic          din_valid = 1'b0;
    logic          frame_sync = 1'b0;
    logic          dout_ready = 1'b0;
    logic [4*W-1:0] dout;
    logic          dout_valid, locked, sync_err, overrun;

    int errCnt = 0;
    int chkCnt = 0;

    // Reference model: beats counted since the last (re)sync.
    bit            mLocked, mValid, mErr, mOvr;
    int            mBeats;
    logic [W-1:0]  mWord [4];
    logic [4*W-1:0] mDout;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .locked     (locked),
        .sync_err   (sync_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mLocked = 0; mValid = 0; mErr = 0; mOvr = 0; mBeats = 0; mDout = '0;
        for (int k = 0; k < 4; k++) mWord[k] = '0;
    endtask

    task automatic modelStep(input logic d, input logic v, input logic fs, input logic rdy);
        bit complete = 0;
        bit err = 0;
        int ch;
        if (v && (mLocked || fs)) begin
            ch = mBeats % 4;
            if (!mLocked || (fs && ch != 0)) begin
                err = mLocked;
                mLocked = 1;
                mBeats = 0;
                ch = 0;
            end
            mWord[ch] = W'(int'(mWord[ch]) * 2 + int'(d));
            complete = (mBeats == 4 * W - 1);
            mBeats = (mBeats + 1) % (4 * W);
        end
        if (complete) begin
            if (!mValid || rdy) begin
                mDout = {mWord[3], mWord[2], mWord[1], mWord[0]};
                mValid = 1;
            end else begin
                mOvr = 1;
            end
        end else if (mValid && rdy) begin
            mValid = 0;
        end
        mErr = err;
    endtask

    task automatic tick(input logic d, input logic v, input logic fs, input logic rdy);
        din = d; din_valid = v; frame_sync = fs; dout_ready = rdy;
        modelStep(d, v, fs, rdy);
        @(posedge clk);
        #1;
        check("dout", 64'(dout), 64'(mDout));
        check("dout_valid", 64'(dout_valid), 64'(mValid));
        check("locked", 64'(locked), 64'(mLocked));
        check("sync_err", 64'(sync_err), 64'(mErr));
        check("overrun", 64'(overrun), 64'(mOvr));
    endtask

    task automatic doReset();
        rst = 1'b1;
        #2;
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_valid", 64'(dout_valid), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_sync_err", 64'(sync_err), 64'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One full frame, MSB first, sync on the first beat; optional idle gaps.
    task automatic sendFrame(input logic [4*W-1:0] set, input bit gaps,
                             input logic rdyDuring, input logic rdyLast,
                             output logic firstErr);
        firstErr = 1'b0;
        for (int b = 0; b < W; b++) begin
            for (int k = 0; k < 4; k++) begin
                if (gaps) begin
                    int n = $urandom_range(0, 3);
                    for (int g = 0; g < n; g++)
                        tick(1'($urandom), 1'b0, 1'($urandom), rdyDuring);
                end
                tick(set[k*W + W - 1 - b], 1'b1, (b == 0 && k == 0),
                     (b == W - 1 && k == 3) ? rdyLast : rdyDuring);
                if (b == 0 && k == 0) firstErr = sync_err;
            end
        end
    endtask

    initial begin
        logic fe;
        modelReset();
        doReset();
        check("reset_locked", 64'(locked), 64'd0);

        // 1: traffic, async reset mid-run, then unsynced beats stay unlocked
        for (int i = 0; i < 40; i++) tick(1'($urandom), 1'b1, (i % 32 == 0), 1'b0);
        #2;
        doReset();
        for (int i = 0; i < 5; i++) tick(1'($urandom), 1'b1, 1'b0, 1'b1);
        check("t1_locked", 64'(locked), 64'd0);

        // 2: clean frame
        sendFrame(32'h00FF3CA5, 1'b0, 1'b1, 1'b1, fe);
        check("t2_dout", 64'(dout), 64'h00FF3CA5);
        check("t2_valid", 64'(dout_valid), 64'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_valid_drop", 64'(dout_valid), 64'd0);

        // 3: same frame with gaps
        sendFrame(32'h00FF3CA5, 1'b1, 1'b1, 1'b1, fe);
        check("t3_dout", 64'(dout), 64'h00FF3CA5);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // 4: consumer stalled across two frames
        sendFrame(32'h12345678, 1'b0, 1'b0, 1'b0, fe);
        sendFrame(32'h9ABCDEF0, 1'b1, 1'b0, 1'b0, fe);
        check("t4_dout_held", 64'(dout), 64'h12345678);
        check("t4_valid", 64'(dout_valid), 64'd1);
        check("t4_overrun", 64'(overrun), 64'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_valid_drop", 64'(dout_valid), 64'd0);

        // 5: misplaced sync at slot 2, then a full frame
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        sendFrame(32'h44332211, 1'b0, 1'b1, 1'b1, fe);
        check("t5_sync_err", 64'(fe), 64'd1);
        check("t5_dout", 64'(dout), 64'h44332211);

        // 6: completion coincides with acceptance of the held set
        doReset();
        sendFrame(32'hCAFEF00D, 1'b0, 1'b0, 1'b0, fe);
        sendFrame(32'h0BADBEEF, 1'b1, 1'b0, 1'b1, fe);
        check("t6_dout", 64'(dout), 64'h0BADBEEF);
        check("t6_valid", 64'(dout_valid), 64'd1);
        check("t6_overrun", 64'(overrun), 64'd0);

        // Random traffic
        for (int i = 0; i < 1500; i++)
            tick(1'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 40) == 0), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
